// File: rtl/dct_8pt_1d_pkg.sv
// Shared constants for the 8-point DCT engine: sizes, the Q1.11 cosine table
// and the round/saturate step applied to each accumulated coefficient.
package dct_pkg;
    localparam int DCT_N  = 8;
    localparam int COEF_W = 12;
    localparam int FRAC   = 11;
    localparam int DATA_W = 25;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + 3;

    // C[k][n] = round(2048 * (c_k/2) * cos((2n+1)k*pi/16)), c_0 = 1/sqrt(2)
    localparam int C_TAB [DCT_N][DCT_N] = '{
        '{ 724,   724,   724,   724,   724,   724,   724,   724},
        '{1004,   851,   569,   200,  -200,  -569,  -851, -1004},
        '{ 946,   392,  -392,  -946,  -946,  -392,   392,   946},
        '{ 851,  -200, -1004,  -569,   569,  1004,   200,  -851},
        '{ 724,  -724,  -724,   724,   724,  -724,  -724,   724},
        '{ 569, -1004,   200,   851,  -851,  -200,  1004,  -569},
        '{ 392,  -946,   946,  -392,  -392,   946,  -946,   392},
        '{ 200,  -569,   851, -1004,  1004,  -851,   569,  -200}
    };

    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) <<< (FRAC - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(1) <<< (DATA_W - 1));

    function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] r;
        r = (acc + RND) >>> FRAC;
        if (r > SAT_MAX)
            round_sat = SAT_MAX[DATA_W-1:0];
        else if (r < SAT_MIN)
            round_sat = SAT_MIN[DATA_W-1:0];
        else
            round_sat = r[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/dct_8pt_1d_if.sv
// Sample/coefficient stream between a DCT stage and its neighbours.
interface dct_8pt_1d_if #(parameter int bits = 25);
    logic signed [bits-1:0] in;
    logic signed [bits-1:0] O;
    logic                   finish;

    modport master (output in, input O, input finish);
    modport slave  (input in, output O, output finish);
endinterface

// File: rtl/dct_8pt_1d_coef_row.sv
// Combinational coefficient ROM: returns the 8 entries of cosine row k.
module dct_coef_row
    import dct_pkg::*;
(
    input  logic [2:0]                    k,
    output logic [DCT_N-1:0][COEF_W-1:0]  row
);
    always_comb begin
        row = '0;
        for (int n = 0; n < DCT_N; n++)
            row[n] = COEF_W'(C_TAB[k][n]);
    end
endmodule

// File: rtl/dct_8pt_1d.sv
// Streaming 8-point DCT-II: one sample in, one coefficient out per clock,
// with the hold register double-buffering so blocks stream gap-free.
module dct_8pt_1d
    import dct_pkg::*;
#(
    parameter int bits = DATA_W
) (
    input logic          clk,
    input logic          rst,
    dct_8pt_1d_if.slave  bus
);
    logic [2:0]                   idx;
    logic [2:0]                   k;
    logic                         out_vld;
    logic [DCT_N-2:0][bits-1:0]   cap;
    logic [DCT_N-1:0][bits-1:0]   hold;
    logic [DCT_N-1:0][COEF_W-1:0] coef;
    logic signed [PROD_W-1:0]     prod [DCT_N];
    logic signed [ACC_W-1:0]      acc;
    logic signed [bits-1:0]       o_q;
    logic                         fin_q;

    dct_coef_row u_rom (.k(k), .row(coef));

    for (genvar g = 0; g < DCT_N; g++) begin : g_mul
        assign prod[g] = PROD_W'($signed(hold[g])) * PROD_W'($signed(coef[g]));
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < DCT_N; i++)
            acc = acc + ACC_W'(prod[i]);
    end

    // x7 goes straight into the hold register alongside x0..x6 from the
    // shift register, so row k=0 of the new block is computed the next cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx     <= '0;
            k       <= '0;
            out_vld <= 1'b0;
            cap     <= '0;
            hold    <= '0;
            o_q     <= '0;
            fin_q   <= 1'b0;
        end else begin
            idx <= idx + 3'd1;
            cap <= {bus.in, cap[DCT_N-2:1]};
            if (idx == 3'(DCT_N - 1)) begin
                hold    <= {bus.in, cap};
                out_vld <= 1'b1;
            end
            if (out_vld) begin
                o_q   <= bits'(round_sat(acc));
                fin_q <= (k == 3'd0);
                k     <= k + 3'd1;
            end
        end
    end

    assign bus.O      = o_q;
    assign bus.finish = fin_q;
endmodule

// File: tb/tb_dct_8pt_1d.sv
// Bench for dct_8pt_1d: table vectors and random rows feed a timed scoreboard.
module tb_dct_8pt_1d;
    localparam int B = 25;
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dct_8pt_1d_if #(.bits(B)) bus();
    dct_8pt_1d #(.bits(B)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { int x[8]; int e[8]; } vec_t;
    typedef struct { int due; int o; bit fin; real fref; bit use_f; } exp_t;

    exp_t q[$];
    vec_t tbl[5];
    int   ctab[8][8];
    int   blk[8];
    int   tbl_e[8];
    int   checks = 0, errors = 0;
    int   edge_n = 0, sidx = 0, last_fin = 0;
    bit   seen_out = 1'b0, push_en = 1'b1, use_tbl = 1'b0, use_float = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", name, edge_n, act, req);
        end
    endtask

    function automatic int model(input int x[8], input int k);
        longint s = 0;
        for (int n = 0; n < 8; n++) s += longint'(x[n]) * longint'(ctab[k][n]);
        s = (s + 64'sd1024) >>> 11;
        if (s > 64'sd16777215) s = 64'sd16777215;
        if (s < -64'sd16777216) s = -64'sd16777216;
        return int'(s);
    endfunction

    function automatic real fref(input int x[8], input int k);
        real c = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        real s = 0.0;
        for (int n = 0; n < 8; n++)
            s += real'(x[n]) * (c / 2.0) * $cos(real'((2 * n + 1) * k) * PI / 16.0);
        return s;
    endfunction

    task automatic monitor();
        exp_t e;
        real  d;
        if (q.size() > 0 && q[0].due == edge_n) begin
            e = q.pop_front();
            check("O", int'(bus.O), e.o);
            check("finish", int'(bus.finish), int'(e.fin));
            if (e.use_f) begin
                d = real'(bus.O) - e.fref;
                checks++;
                if (d > 1.0 || d < -1.0) begin
                    errors++;
                    $display("FAIL float_ref @edge %0d: got %0d expected %f +-1", edge_n, bus.O, e.fref);
                end
            end
            seen_out = 1'b1;
        end else begin
            check("finish_idle", int'(bus.finish), 0);
            if (!seen_out) check("O_idle", int'(bus.O), 0);
        end
        if (bus.finish) begin
            if (last_fin > 0) check("finish_gap", edge_n - last_fin, 8);
            last_fin = edge_n;
        end
    endtask

    task automatic step(input int s);
        exp_t e;
        bus.in = B'(s);
        blk[sidx] = s;
        if (sidx == 7 && push_en) begin
            for (int k = 0; k < 8; k++) begin
                e.due   = edge_n + 2 + k;
                e.o     = use_tbl ? tbl_e[k] : model(blk, k);
                e.fin   = (k == 0);
                e.fref  = fref(blk, k);
                e.use_f = use_float;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        edge_n++;
        sidx = (sidx + 1) % 8;
        monitor();
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            edge_n++;
            check("rst_O", int'(bus.O), 0);
            check("rst_finish", int'(bus.finish), 0);
        end
        q.delete();
        sidx = 0;
        seen_out = 1'b0;
        last_fin = 0;
        rst = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 8; k++)
            for (int n = 0; n < 8; n++)
                ctab[k][n] = int'(1024.0 * ((k == 0) ? 1.0 / $sqrt(2.0) : 1.0) *
                                  $cos(real'((2 * n + 1) * k) * PI / 16.0));

        tbl[0].x = '{2048, 0, 0, 0, 0, 0, 0, 0};
        tbl[0].e = '{724, 1004, 946, 851, 724, 569, 392, 200};
        tbl[1].x = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
        tbl[1].e = '{2828, 0, 0, 0, 0, 0, 0, 0};
        tbl[2].x = '{1000, -1000, 1000, -1000, 1000, -1000, 1000, -1000};
        tbl[2].e = '{0, 510, 0, 602, 0, 900, 0, 2563};
        tbl[3].x = '{16777215, 16777215, 16777215, 16777215, 16777215, 16777215, 16777215, 16777215};
        tbl[3].e = '{16777215, 0, 0, 0, 0, 0, 0, 0};
        tbl[4].x = '{-16777216, -16777216, -16777216, -16777216, -16777216, -16777216, -16777216, -16777216};
        tbl[4].e = '{-16777216, 0, 0, 0, 0, 0, 0, 0};

        bus.in = '0;
        do_reset(3);

        use_tbl = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tbl_e = tbl[i].e;
            for (int n = 0; n < 8; n++) step(tbl[i].x[n]);
        end

        // 8 random rows back-to-back, checked bit-exact and against real DCT
        use_tbl = 1'b0;
        use_float = 1'b1;
        for (int r = 0; r < 8; r++)
            for (int n = 0; n < 8; n++) step(int'($urandom_range(400)) - 200);

        // partial block then reset: nothing from before may leak out
        use_float = 1'b0;
        for (int n = 0; n < 5; n++) step(int'($urandom_range(4000)) - 2000);
        do_reset(1);
        use_tbl = 1'b1;
        tbl_e = tbl[0].e;
        for (int n = 0; n < 8; n++) step(tbl[0].x[n]);

        push_en = 1'b0;
        for (int i = 0; i < 16 && q.size() > 0; i++) step(0);
        check("drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
